// File: rtl/mio_bus_gen.sv
// mio_bus_gen: CPU memory/IO bus controller with RAM latency, per-channel ready handshake and timeout.
// Define MIO_BUS_ERRCNT_EN to enable the saturating error counter on err_cnt.
module mio_bus_gen #(
    parameter int         NCH     = 4,
    parameter logic [3:0] CH_BASE = 4'hC,
    parameter int         DW      = 32,
    parameter int         RAM_AW  = 10,
    parameter int         LAW     = 8,
    parameter int         RAM_LAT = 2,
    parameter int         TO_CYC  = 16
) (
    input  logic              clk,
    input  logic              RSTN,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DW-1:0]     cpu_wdata,
    output logic [DW-1:0]     cpu_rdata,
    output logic              mio_ready,
    output logic              busy,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_wdata,
    output logic              ram_we,
    input  logic [DW-1:0]     ram_rdata,
    output logic [LAW-1:0]    ch_addr,
    output logic [DW-1:0]     ch_wdata,
    output logic [NCH-1:0]    ch_we,
    output logic [NCH-1:0]    ch_re,
    input  logic [NCH*DW-1:0] ch_rdata,
    input  logic [NCH-1:0]    ch_ready,
    input  logic              err_clr,
    output logic              bus_err,
    output logic [7:0]        err_cnt
);
    localparam int CW = $clog2(TO_CYC > RAM_LAT ? TO_CYC : RAM_LAT) + 1;
    typedef enum logic [1:0] {IDLE, RAM_WAIT, IO_WAIT, DONE} state_t;
    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic              we_q, mio_ready_q, ram_we_q, bus_err_q, bus_err_d;
    logic [1:0]        sel_q, idx;
    logic [DW-1:0]     cpu_rdata_q, ram_wdata_q, ch_wdata_q;
    logic [RAM_AW-1:0] ram_addr_q;
    logic [LAW-1:0]    ch_addr_q;
    logic [NCH-1:0]    ch_we_q, ch_re_q, oh;
    logic [3:0]        nib;
    logic [4:0]        off;
    logic              is_ram, is_ch, err_ev;
    logic              unused;

    assign unused = ^cpu_addr;

    always_comb begin
        nib    = cpu_addr[31:28];
        off    = {1'b0, nib} - {1'b0, CH_BASE};
        is_ram = nib == 4'h0;
        is_ch  = !is_ram && nib >= CH_BASE && off < 5'(NCH);
        idx    = off[1:0];
        oh     = NCH'(1) << idx;
        err_ev = (state_q == IDLE && cpu_req && !is_ram && !is_ch) ||
                 (state_q == IO_WAIT && !ch_ready[sel_q] && cnt_q == '0);
        bus_err_d = err_ev | (bus_err_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            mio_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            ch_addr_q   <= '0;
            ch_wdata_q  <= '0;
            ch_we_q     <= '0;
            ch_re_q     <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            ram_we_q    <= 1'b0;
            ch_we_q     <= '0;
            ch_re_q     <= '0;
            mio_ready_q <= 1'b0;
            bus_err_q   <= bus_err_d;
            case (state_q)
                IDLE: if (cpu_req) begin
                    we_q <= cpu_we;
                    if (is_ram) begin
                        state_q     <= RAM_WAIT;
                        cnt_q       <= CW'(RAM_LAT - 1);
                        ram_addr_q  <= cpu_addr[RAM_AW+1:2];
                        ram_wdata_q <= cpu_wdata;
                        ram_we_q    <= cpu_we;
                    end else if (is_ch) begin
                        state_q    <= IO_WAIT;
                        cnt_q      <= CW'(TO_CYC - 1);
                        sel_q      <= idx;
                        ch_addr_q  <= cpu_addr[LAW+1:2];
                        ch_wdata_q <= cpu_wdata;
                        ch_we_q    <= cpu_we ? oh : '0;
                        ch_re_q    <= cpu_we ? '0 : oh;
                    end else begin
                        state_q     <= DONE;
                        mio_ready_q <= 1'b1;
                        if (!cpu_we) cpu_rdata_q <= '0;
                    end
                end
                RAM_WAIT: if (cnt_q == '0) begin
                    state_q     <= DONE;
                    mio_ready_q <= 1'b1;
                    if (!we_q) cpu_rdata_q <= ram_rdata;
                end else cnt_q <= cnt_q - 1'b1;
                // ready is checked before the timeout, so a ready on the last cycle still completes cleanly
                IO_WAIT: if (ch_ready[sel_q] || cnt_q == '0) begin
                    state_q     <= DONE;
                    mio_ready_q <= 1'b1;
                    if (!we_q) cpu_rdata_q <= ch_ready[sel_q] ? ch_rdata[sel_q*DW +: DW] : '1;
                end else cnt_q <= cnt_q - 1'b1;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MIO_BUS_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    always_comb err_cnt_d = err_ev ? (err_clr ? 8'd1 : err_cnt_q + {7'd0, err_cnt_q != 8'hFF})
                                   : (err_clr ? 8'd0 : err_cnt_q);
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end
    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

    assign busy      = state_q != IDLE;
    assign mio_ready = mio_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign ch_addr   = ch_addr_q;
    assign ch_wdata  = ch_wdata_q;
    assign ch_we     = ch_we_q;
    assign ch_re     = ch_re_q;
    assign bus_err   = bus_err_q;
endmodule

// File: tb/tb_mio_bus_gen.sv
// tb_mio_bus_gen: directed and random transactions against a transaction-level model of mio_bus_gen.
// Expected err_cnt follows MIO_BUS_ERRCNT_EN.
module tb_mio_bus_gen;
    localparam int RAM_LAT = 2;
    localparam int TO_CYC  = 16;

    logic        clk = 1'b0, RSTN = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, err_clr = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, ram_rdata = '0;
    logic [31:0] cpu_rdata, ram_wdata, ch_wdata;
    logic        mio_ready, busy, ram_we, bus_err;
    logic [9:0]  ram_addr;
    logic [7:0]  ch_addr, err_cnt;
    logic [3:0]  ch_we, ch_re, ch_ready = '0;
    logic [127:0] ch_rdata = '0;

    mio_bus_gen #(.NCH(4), .CH_BASE(4'hC), .DW(32), .RAM_AW(10), .LAW(8),
                  .RAM_LAT(RAM_LAT), .TO_CYC(TO_CYC)) dut (
        .clk(clk), .RSTN(RSTN), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .mio_ready(mio_ready), .busy(busy),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_we(ch_we), .ch_re(ch_re),
        .ch_rdata(ch_rdata), .ch_ready(ch_ready), .err_clr(err_clr), .bus_err(bus_err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [31:0] m_rdata = '0;
    logic        m_err = 1'b0;
    int          m_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_cnt();
`ifdef MIO_BUS_ERRCNT_EN
        return 8'(m_cnt);
`else
        return 8'd0;
`endif
    endfunction

    // One complete transaction; d = IO_WAIT cycle index at which the selected ch_ready rises.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rv, input int d, input logic clr);
        int kind, k, lat, obs_lat, extra;
        logic [3:0] oh;
        logic [9:0] first;
        logic tmo, err_ev;
        k    = int'(addr[31:28]) - 12;
        kind = addr[31:28] == 4'h0 ? 0 : (k >= 0 && k < 4) ? 1 : 2;
        oh   = kind == 1 ? 4'(1 << k) : 4'b0;
        tmo  = kind == 1 && d >= TO_CYC;
        err_ev = kind == 2 || tmo;
        lat  = kind == 0 ? RAM_LAT + 1 : kind == 1 ? (tmo ? TO_CYC + 1 : d + 2) : 1;
        ram_rdata = kind == 0 ? rv : $urandom;
        for (int i = 0; i < 4; i++) ch_rdata[i*32 +: 32] = (kind == 1 && i == k) ? rv : $urandom;
        if (!we) m_rdata = kind == 0 ? rv : kind == 2 ? 32'h0 : tmo ? 32'hFFFF_FFFF : rv;
        if (clr) begin m_err = 1'b0; m_cnt = 0; end
        if (err_ev) begin m_err = 1'b1; m_cnt = m_cnt < 255 ? m_cnt + 1 : 255; end
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; err_clr = clr;
        ch_ready = 4'($urandom) & ~oh;
        obs_lat = 99; extra = 0; first = '0;
        for (int n = 1; n <= 64 && obs_lat == 99; n++) begin
            cyc;
            err_clr = 1'b0;
            if (n == 1) first = {busy, ram_we, ch_we, ch_re};
            else extra += int'(ram_we | (|ch_we) | (|ch_re));
            ch_ready = (4'($urandom) & ~oh) | ((n - 1 >= d) ? oh : 4'b0);
            if (mio_ready) obs_lat = n;
        end
        chk("latency", 64'(obs_lat), 64'(lat));
        chk("first_strobes", 64'(first), 64'({1'b1, kind == 0 && we, we ? oh : 4'b0, we ? 4'b0 : oh}));
        chk("extra_strobes", 64'(extra), 64'd0);
        chk("cpu_rdata", 64'(cpu_rdata), 64'(m_rdata));
        chk("bus_err", 64'(bus_err), 64'(m_err));
        chk("err_cnt", 64'(err_cnt), 64'(exp_cnt()));
        if (kind == 0) chk("ram_addr_wdata", {ram_addr, ram_wdata}, {addr[11:2], wd});
        if (kind == 1) chk("ch_addr_wdata", {ch_addr, ch_wdata}, {addr[9:2], wd});
        cpu_req = 1'b0;
        cyc;
        chk("back_to_idle", 64'({mio_ready, busy}), 64'd0);
    endtask

    task automatic clear_err;
        err_clr = 1'b1;
        cyc;
        err_clr = 1'b0;
        m_err = 1'b0; m_cnt = 0;
        chk("clr_bus_err", 64'(bus_err), 64'd0);
        chk("clr_err_cnt", 64'(err_cnt), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {cpu_rdata, mio_ready, busy, ram_we, ch_we, ch_re, bus_err, err_cnt},  64'd0);
        chk({tag, "_regs"}, {ram_addr, ram_wdata, ch_addr}, 64'd0);
        chk({tag, "_chw"}, 64'(ch_wdata), 64'd0);
    endtask

    initial begin
        logic [3:0] nib;
        int d;
        cyc; cyc;
        chk_all_zero("reset");
        RSTN = 1'b1;
        cyc;
        txn(1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, 1'b0);
        txn(1'b1, 32'hE000_0000, 32'hA5A5_A5A5, 32'h0, 0, 1'b0);
        txn(1'b0, 32'hC000_0008, 32'h0, 32'hCAFE_F00D, 5, 1'b0);
        txn(1'b0, 32'hD000_0000, 32'h0, 32'h0, 1000, 1'b0);
        txn(1'b0, 32'h5000_0000, 32'h0, 32'h0, 0, 1'b0);
        clear_err;
        txn(1'b0, 32'hF000_0004, 32'h0, 32'h0BAD_BEEF, TO_CYC - 1, 1'b0);
        txn(1'b0, 32'hF000_0004, 32'h0, 32'h0BAD_BEEF, TO_CYC, 1'b0);
        txn(1'b1, 32'h0000_0ABC, 32'h1111_2222, 32'h3333_4444, 0, 1'b0);
        txn(1'b1, 32'hC000_0000, 32'h5555_6666, 32'h7777_8888, TO_CYC, 1'b0);
        txn(1'b0, 32'h1000_0000, 32'h0, 32'h0, 0, 1'b1);
        txn(1'b0, 32'h0000_0100, 32'h0, 32'h9999_AAAA, 0, 1'b1);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hC000_0000; ch_ready = 4'b0;
        cyc; cyc; cyc;
        RSTN = 1'b0;
        #1;
        chk_all_zero("reset_mid_io");
        cpu_req = 1'b0;
        m_rdata = '0; m_err = 1'b0; m_cnt = 0;
        cyc;
        RSTN = 1'b1;
        cyc;
        txn(1'b0, 32'hC000_0000, 32'h0, 32'h1357_9BDF, 2, 1'b0);
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 4))
                0, 1: nib = 4'h0;
                2, 3: nib = 4'(12 + $urandom_range(0, 3));
                default: nib = 4'($urandom_range(1, 11));
            endcase
            d = ($urandom_range(0, 3) == 0) ? $urandom_range(TO_CYC - 1, TO_CYC + 2) : $urandom_range(0, 6);
            txn(1'($urandom), {nib, 28'($urandom)}, $urandom, $urandom, d, $urandom_range(0, 7) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
